// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and the MEM stage.
// One access at a time, MEM has priority, registered bus outputs, optional ack timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, DATA_BUSY, INST_BUSY} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [3:0]        bus_sel_reg, bus_sel_next;
    logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic              bus_err_reg, bus_err_next;
    logic              if_done_reg, if_done_next;
    logic              mem_done_reg, mem_done_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
    logic              mem_elig, if_elig, timeout_hit;

    // A requester still showing its done pulse is finishing the previous access.
    assign mem_elig    = (mem_re | mem_we) & ~mem_done_reg;
    assign if_elig     = if_req & ~if_done_reg;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_sel_reg   <= '0;
            bus_wdata_reg <= '0;
            bus_err_reg   <= 1'b0;
            if_done_reg   <= 1'b0;
            mem_done_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_sel_reg   <= bus_sel_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_err_reg   <= bus_err_next;
            if_done_reg   <= if_done_next;
            mem_done_reg  <= mem_done_next;
            if_rdata_reg  <= if_rdata_next;
            mem_rdata_reg <= mem_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_sel_next   = bus_sel_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_err_next   = 1'b0;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (mem_elig) begin
                    state_next     = DATA_BUSY;
                    cnt_next       = '0;
                    bus_req_next   = 1'b1;
                    bus_we_next    = mem_we;
                    bus_addr_next  = mem_addr;
                    bus_sel_next   = mem_sel;
                    bus_wdata_next = mem_wdata;
                end else if (if_elig) begin
                    state_next    = INST_BUSY;
                    cnt_next      = '0;
                    bus_req_next  = 1'b1;
                    bus_we_next   = 1'b0;
                    bus_addr_next = if_addr;
                    bus_sel_next  = 4'b1111;
                end
            end
            DATA_BUSY, INST_BUSY: begin
                if (bus_ack) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                    if (state_reg == DATA_BUSY) begin
                        mem_done_next  = 1'b1;
                        mem_rdata_next = bus_we_reg ? '0 : bus_rdata;
                    end else begin
                        if_done_next  = 1'b1;
                        if_rdata_next = bus_rdata;
                    end
                end else if (timeout_hit) begin
                    // Abort: the owner still gets a done so the pipeline cannot deadlock.
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                    bus_err_next = 1'b1;
                    if (state_reg == DATA_BUSY) begin
                        mem_done_next  = 1'b1;
                        mem_rdata_next = '0;
                    end else begin
                        if_done_next  = 1'b1;
                        if_rdata_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_sel   = bus_sel_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_err   = bus_err_reg;
    assign if_done   = if_done_reg;
    assign mem_done  = mem_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;
    assign stall_if  = if_req & ~if_done_reg;
    assign stall_mem = (mem_re | mem_we) & ~mem_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, write, contention, timeout, reset mid-access.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stall_if, stall_mem;
    logic              bus_req, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_sel;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = '0; mem_re = 0; mem_we = 0;
        mem_addr = '0; mem_sel = '0; mem_wdata = '0; bus_rdata = 32'hCAFE_0001; bus_ack = 1'b1;

        // 1: reset with ack pulses present, then ack in IDLE with no request
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_addr", 32'(bus_addr), 32'd0);
        check("rst bus_sel", 32'(bus_sel), 32'd0);
        check("rst dones", {30'd0, if_done, mem_done}, 32'd0);
        check("rst bus_err", 32'(bus_err), 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        bus_ack = 1'b0;

        // 2: fetch, ack on the third busy cycle
        if_req = 1; if_addr = 30'h10;
        #1 check("fetch stall_if", 32'(stall_if), 32'd1);
        tick();
        check("fetch bus_req", 32'(bus_req), 32'd1);
        check("fetch bus_sel", 32'(bus_sel), 32'hF);
        check("fetch bus_addr", 32'(bus_addr), 32'h10);
        check("fetch bus_we", 32'(bus_we), 32'd0);
        tick(); tick();
        check("fetch hold bus_req", 32'(bus_req), 32'd1);
        check("fetch no early done", 32'(if_done), 32'd0);
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        check("fetch if_done", 32'(if_done), 32'd1);
        check("fetch if_rdata", if_rdata, 32'hDEADBEEF);
        check("fetch bus_req off", 32'(bus_req), 32'd0);
        check("fetch stall_if done", 32'(stall_if), 32'd0);
        check("fetch mem_done", 32'(mem_done), 32'd0);
        bus_ack = 0; if_req = 0;
        tick();
        check("fetch done pulse", 32'(if_done), 32'd0);
        check("fetch no regrant", 32'(bus_req), 32'd0);

        // 4: write, fields frozen while inputs change
        mem_we = 1; mem_addr = 30'h20; mem_sel = 4'b0011; mem_wdata = 32'h1234;
        tick();
        check("wr bus_we", 32'(bus_we), 32'd1);
        mem_addr = 30'h99; mem_sel = 4'hF; mem_wdata = 32'h5555;
        tick();
        check("wr addr frozen", 32'(bus_addr), 32'h20);
        check("wr sel frozen", 32'(bus_sel), 32'h3);
        check("wr wdata frozen", bus_wdata, 32'h1234);
        check("wr stall_mem", 32'(stall_mem), 32'd1);
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        check("wr mem_done", 32'(mem_done), 32'd1);
        check("wr mem_rdata", mem_rdata, 32'd0);
        bus_ack = 0; mem_we = 0;
        tick();
        check("wr done pulse", 32'(mem_done), 32'd0);

        // 3: contention, MEM read first then fetch
        if_req = 1; if_addr = 30'h44; mem_re = 1; mem_addr = 30'h80; mem_sel = 4'hF;
        tick();
        check("cont first addr", 32'(bus_addr), 32'h80);
        bus_ack = 1; bus_rdata = 32'hA5A5_A5A5;
        tick();
        check("cont mem_done", 32'(mem_done), 32'd1);
        check("cont mem_rdata", mem_rdata, 32'hA5A5_A5A5);
        check("cont if_done", 32'(if_done), 32'd0);
        check("cont stall_if", 32'(stall_if), 32'd1);
        bus_ack = 0; mem_re = 0;
        tick();
        check("cont fetch granted", 32'(bus_req), 32'd1);
        check("cont fetch addr", 32'(bus_addr), 32'h44);
        check("cont fetch sel", 32'(bus_sel), 32'hF);
        bus_ack = 1; bus_rdata = 32'h1111_2222;
        tick();
        check("cont if_done", 32'(if_done), 32'd1);
        check("cont if_rdata", if_rdata, 32'h1111_2222);
        check("cont mem_rdata hold", mem_rdata, 32'hA5A5_A5A5);
        bus_ack = 0; if_req = 0;
        tick();

        // 5: timeout with TIMEOUT=4
        mem_re = 1; mem_addr = 30'h30; bus_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to bus_req c%0d", i + 1), 32'(bus_req), 32'd1);
            check($sformatf("to no err c%0d", i + 1), 32'(bus_err), 32'd0);
        end
        tick();
        check("to bus_req off", 32'(bus_req), 32'd0);
        check("to bus_err", 32'(bus_err), 32'd1);
        check("to mem_done", 32'(mem_done), 32'd1);
        check("to mem_rdata", mem_rdata, 32'd0);
        mem_re = 0;
        tick();
        check("to err pulse", 32'(bus_err), 32'd0);

        // 6: reset during INST_BUSY, request kept high and re-served
        if_req = 1; if_addr = 30'h55;
        tick();
        check("rstmid bus_req", 32'(bus_req), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        check("rstmid bus_req off", 32'(bus_req), 32'd0);
        check("rstmid no if_done", 32'(if_done), 32'd0);
        tick();
        check("rstmid regrant", 32'(bus_req), 32'd1);
        check("rstmid addr", 32'(bus_addr), 32'h55);
        bus_ack = 1; bus_rdata = 32'h0000_600D;
        tick();
        check("rstmid if_done", 32'(if_done), 32'd1);
        check("rstmid if_rdata", if_rdata, 32'h0000_600D);
        bus_ack = 0; if_req = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
